// File: rtl/scan_slot_bank.sv
// Slot register bank scanned by a ring pointer that steps every DIV clocks, with scan-load and addressed writes.
// Read data and seven-segment decode are registered and write-through. There is no backpressure: writes always land.
module scan_slot_bank #(
  parameter int SLOTS = 4,
  parameter int WIDTH = 4,
  parameter int DIV   = 1,
  parameter int AW    = $clog2(SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             scan_load,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [SLOTS-1:0] scan_onehot,
  output logic [AW-1:0]    scan_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic [6:0]       seg,
  output logic             frame_start
);

  localparam int            PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [AW-1:0] IDX_MAX   = AW'(SLOTS - 1);
  localparam logic [AW:0]   SLOTS_EXT = (AW + 1)'(SLOTS);

  logic [WIDTH-1:0] slot_q [SLOTS];
  logic [WIDTH-1:0] slot_d [SLOTS];
  logic [AW-1:0]    scan_idx_q, scan_idx_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_start_q, frame_start_d;
  logic             step;
  logic             addr_ok;

  function automatic logic [6:0] hexfont(input logic [3:0] v);
    case (v)
      4'h0:    hexfont = 7'h3F;
      4'h1:    hexfont = 7'h06;
      4'h2:    hexfont = 7'h5B;
      4'h3:    hexfont = 7'h4F;
      4'h4:    hexfont = 7'h66;
      4'h5:    hexfont = 7'h6D;
      4'h6:    hexfont = 7'h7D;
      4'h7:    hexfont = 7'h07;
      4'h8:    hexfont = 7'h7F;
      4'h9:    hexfont = 7'h6F;
      4'hA:    hexfont = 7'h77;
      4'hB:    hexfont = 7'h7C;
      4'hC:    hexfont = 7'h39;
      4'hD:    hexfont = 7'h5E;
      4'hE:    hexfont = 7'h79;
      default: hexfont = 7'h71;
    endcase
  endfunction

  // Prescaler and scanner: hold freezes both at the edge it is sampled.
  always_comb begin
    step          = (presc_q == PRESC_MAX) && !hold;
    presc_d       = presc_q;
    scan_idx_d    = scan_idx_q;
    frame_start_d = step && (scan_idx_q == IDX_MAX);
    if (step) begin
      presc_d    = '0;
      scan_idx_d = (scan_idx_q == IDX_MAX) ? '0 : scan_idx_q + 1'b1;
    end else if (!hold) begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Both write paths carry the same data, so ordering only matters for clarity.
  always_comb begin
    addr_ok = ({1'b0, wr_addr} < SLOTS_EXT);
    slot_d  = slot_q;
    if (scan_load) begin
      slot_d[scan_idx_q] = wr_data;
    end
    if (wr_en && addr_ok) begin
      slot_d[wr_addr] = wr_data;
    end
    rd_data_d = slot_d[scan_idx_q];
    seg_d     = hexfont(rd_data_d[3:0]);
  end

  // One-hot view is decoded from the index so the two can never disagree.
  always_comb begin
    scan_onehot             = '0;
    scan_onehot[scan_idx_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= '0;
      end
      scan_idx_q    <= '0;
      presc_q       <= '0;
      rd_data_q     <= '0;
      seg_q         <= 7'h3F;
      frame_start_q <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      scan_idx_q    <= scan_idx_d;
      presc_q       <= presc_d;
      rd_data_q     <= rd_data_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign scan_idx    = scan_idx_q;
  assign rd_data     = rd_data_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_scan_slot_bank.sv
// Directed bench for scan_slot_bank: three instances (4 slots DIV=1, 4 slots DIV=3, 5 slots DIV=1) share stimulus.
module tb_scan_slot_bank;

  logic       clk = 1'b0;
  logic       rst, hold, scan_load, wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;

  logic [3:0] d1_oh, d3_oh;
  logic [1:0] d1_idx, d3_idx;
  logic [3:0] d1_rd, d3_rd;
  logic [6:0] d1_seg, d3_seg;
  logic       d1_fs, d3_fs;
  logic [4:0] d5_oh;
  logic [2:0] d5_idx;
  logic [3:0] d5_rd;
  logic [6:0] d5_seg;
  logic       d5_fs;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] vals [4] = '{4'h1, 4'hA, 4'h5, 4'hF};
  logic [6:0] segs [4] = '{7'h06, 7'h77, 7'h6D, 7'h71};

  always #5 clk = ~clk;

  scan_slot_bank #(.SLOTS(4), .WIDTH(4), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .hold(hold), .scan_load(scan_load), .wr_en(wr_en),
    .wr_addr(wr_addr[1:0]), .wr_data(wr_data), .scan_onehot(d1_oh), .scan_idx(d1_idx),
    .rd_data(d1_rd), .seg(d1_seg), .frame_start(d1_fs));

  scan_slot_bank #(.SLOTS(4), .WIDTH(4), .DIV(3)) dut3 (
    .clk(clk), .rst(rst), .hold(hold), .scan_load(scan_load), .wr_en(wr_en),
    .wr_addr(wr_addr[1:0]), .wr_data(wr_data), .scan_onehot(d3_oh), .scan_idx(d3_idx),
    .rd_data(d3_rd), .seg(d3_seg), .frame_start(d3_fs));

  scan_slot_bank #(.SLOTS(5), .WIDTH(4), .DIV(1)) dut5 (
    .clk(clk), .rst(rst), .hold(hold), .scan_load(scan_load), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .scan_onehot(d5_oh), .scan_idx(d5_idx),
    .rd_data(d5_rd), .seg(d5_seg), .frame_start(d5_fs));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hold      = 1'b0;
    scan_load = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Activity before and during reset
    wr_en = 1'b1; scan_load = 1'b1; wr_addr = 3'd1; wr_data = 4'h7;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_inputs();
    check("rst_oh", d3_oh, 4'b0001);
    check("rst_idx", d3_idx, 0);
    check("rst_rd", d3_rd, 0);
    check("rst_seg", d3_seg, 7'h3F);
    check("rst_fs", d3_fs, 0);
    check("rst_d1_seg", d1_seg, 7'h3F);

    // Rotation: DIV=3 steps every 3 clocks, DIV=1 every clock
    for (int k = 1; k <= 13; k++) begin
      tick();
      check("rot_idx", d3_idx, (k / 3) % 4);
      check("rot_oh", d3_oh, 1 << ((k / 3) % 4));
      check("rot_fs", d3_fs, (k == 12));
      check("rot_d1_fs", d1_fs, (k % 4 == 0));
      if (k <= 4) check("rst_slots_zero", d1_rd, 0);
    end

    // Addressed writes with write-through, then readback lagging the scanner
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = vals[i];
      tick();
      check("wt_rd", d1_rd, vals[i]);
    end
    clear_inputs();
    for (int j = 0; j < 4; j++) begin
      tick();
      check("rb_rd", d1_rd, vals[j]);
      check("rb_seg", d1_seg, segs[j]);
      check("rb_idx", d1_idx, (j + 1) % 4);
    end

    // Scan-load with collision and with a different addressed slot (DIV=3)
    do_reset();
    repeat (6) tick();
    check("col_idx", d3_idx, 2);
    scan_load = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'hC;
    tick();
    check("col_rd", d3_rd, 4'hC);
    check("col_seg", d3_seg, 7'h39);
    wr_addr = 3'd0; wr_data = 4'h9;
    tick();
    check("dual_rd", d3_rd, 4'h9);
    check("dual_seg", d3_seg, 7'h6F);
    clear_inputs();
    tick();
    check("dual_slot2", d3_rd, 4'h9);
    check("dual_idx", d3_idx, 3);
    tick();
    check("dual_slot3", d3_rd, 0);
    repeat (2) tick();
    tick();
    check("dual_slot0", d3_rd, 4'h9);
    repeat (2) tick();
    tick();
    check("dual_slot1", d3_rd, 0);

    // Hold at idx 1, prescaler 1
    do_reset();
    repeat (4) tick();
    check("hold_pre_idx", d3_idx, 1);
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_idx", d3_idx, 1);
      check("hold_d1_idx", d1_idx, 0);
    end
    hold = 1'b0;
    tick();
    check("hold_rel1", d3_idx, 1);
    tick();
    check("hold_rel2", d3_idx, 2);

    // Reset mid-frame at the edge that would wrap 3 -> 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i + 1);
      tick();
    end
    clear_inputs();
    repeat (7) tick();
    check("mid_pre_idx", d3_idx, 3);
    rst = 1'b1; scan_load = 1'b1; wr_data = 4'h7;
    tick();
    rst = 1'b0;
    clear_inputs();
    check("mid_oh", d3_oh, 4'b0001);
    check("mid_idx", d3_idx, 0);
    check("mid_fs", d3_fs, 0);
    check("mid_rd", d3_rd, 0);
    check("mid_seg", d3_seg, 7'h3F);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("mid_slots_zero", d3_rd, 0);
      check("mid_step_idx", d3_idx, (k / 3) % 4);
      check("mid_fs_seq", d3_fs, (k == 12));
    end

    // Out-of-range addresses on a 5-slot bank are ignored; slot 4 is writable
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      clear_inputs();
      if (k <= 3) begin
        wr_en = 1'b1; wr_addr = 3'(4 + k); wr_data = 4'hF;
      end else if (k == 4) begin
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 4'h6;
      end
      tick();
      check("oor_rd", d5_rd, (((k - 1) % 5) == 4) ? 6 : 0);
      check("oor_fs", d5_fs, (k % 5 == 0));
      check("oor_oh", d5_oh, 1 << (k % 5));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
